gamepad_reader: RTL and testbench
=================================

GAMEPAD_READER -- requirements
Module: gamepad_reader

Interface
REQ-001 SHALL have parameter DIV, default 4: clk cycles per pad-clock half-period; legal range 4..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_poll  input  1  one-cycle read request, e.g. once per frame.
REQ-005 SHALL have port i_data  input  1  serial data from the SNES-style pad, active-low, asynchronous.
REQ-006 SHALL have port o_latch  output  1  pad latch strobe, active-high.
REQ-007 SHALL have port o_pclk  output  1  pad shift clock, idle high.
REQ-008 SHALL have ports o_up, o_down, o_left, o_right, o_start  output  1 each  registered button state, 1 = pressed.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse when button outputs update.
REQ-010 SHALL have port o_busy  output  1  high while a read is in progress.
REQ-011 SHALL have port o_present  output  1  pad detected on last completed read.

Function
REQ-012 SHALL pass i_data through a 2-flop synchroniser before any use.
REQ-013 SHALL implement states IDLE, LATCH, LOW, HIGH, DONE.
REQ-014 SHALL, in IDLE with i_poll=1, enter LATCH next cycle; o_latch=1 for exactly 2*DIV cycles; o_pclk stays high.
REQ-015 SHALL, after LATCH, run 16 bit slots; each slot = LOW (o_pclk=0, DIV cycles) then HIGH (o_pclk=1, DIV cycles).
REQ-016 SHALL sample the synchronised data into a 16-bit shift register on the last cycle of each LOW phase; bit n is taken in slot n.
REQ-017 SHALL use a 4-bit slot counter; after the HIGH phase of slot 15 it SHALL enter DONE, never wrapping into slot 0.
REQ-018 SHALL, in DONE, update the button outputs, pulse o_valid for 1 cycle, and return to IDLE next cycle.
REQ-019 SHALL have a total read length of 2*DIV + 32*DIV cycles from the first o_latch cycle to the DONE cycle.
REQ-020 SHALL use bit order B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R,id0..id3 for bits 0..15.
REQ-021 SHALL set each button output to the inverse of its raw bit: start=~b3, up=~b4, down=~b5, left=~b6, right=~b7.
REQ-022 SHALL set o_present=0 when all 16 raw bits are 0 (unplugged line pulled low), and SHALL then force all button outputs to 0.
REQ-023 SHALL ignore i_poll while o_busy=1; the request is not queued.
REQ-024 SHALL hold o_busy=1 in LATCH, LOW, HIGH and DONE, and 0 in IDLE.
REQ-025 SHALL hold button outputs stable between o_valid pulses.
REQ-026 SHALL never assert more than one of up/down, or more than one of left/right; if both raw bits of a pair read pressed, both outputs of that pair SHALL be 0.

Reset
REQ-027 SHALL, on rst_n=0, set: state IDLE, o_latch=0, o_pclk=1, all buttons 0, o_valid=0, o_busy=0, o_present=0, counters 0, synchroniser flops 1.
REQ-028 SHALL abandon any read in progress on reset mid-operation, with no o_valid pulse.

Structure
REQ-029 SHALL place the state enum and the SNES bit-index constants in the shared game package.
REQ-030 SHALL instantiate one sub-module, sync2, for the data synchroniser; the divider and slot counters stay inline.

Verification
REQ-031 SHALL cover, with DIV=4: pad model driving Up+Start (raw 16'hFFE7) -> o_latch high 8 cycles, 16 o_pclk falling edges, o_valid at cycle 136, o_up=1, o_start=1, others 0, o_present=1.
REQ-032 SHALL cover: i_data tied 0 -> o_present=0 and all buttons 0 after o_valid.
REQ-033 SHALL cover: raw bits 5 and 4 both low (up+down) -> o_up=0 and o_down=0, while left/right decode normally.
REQ-034 SHALL cover: i_poll pulsed at cycles 10 and 50 of a read -> exactly one o_valid, and no extra latch.
REQ-035 SHALL cover: rst_n low during slot 7 -> o_pclk=1, o_latch=0 and o_busy=0 next cycle, buttons 0, no o_valid.
REQ-036 SHALL cover: back-to-back reads with Left then Right -> o_left=1 after read 1, then o_left=0 and o_right=1 after read 2.

Source files
------------

// File: rtl/gamepad_reader_pkg.sv
// ============================================================================
// gamepad_reader_pkg : shared states, SNES bit map and button decode  (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package gamepad_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int BIT_B      = 0;
   localparam int BIT_Y      = 1;
   localparam int BIT_SELECT = 2;
   localparam int BIT_START  = 3;
   localparam int BIT_UP     = 4;
   localparam int BIT_DOWN   = 5;
   localparam int BIT_LEFT   = 6;
   localparam int BIT_RIGHT  = 7;
   localparam int BIT_A      = 8;
   localparam int BIT_X      = 9;
   localparam int BIT_L      = 10;
   localparam int BIT_R      = 11;
   localparam int BIT_ID0    = 12;

   typedef struct packed {
      logic present;
      logic up;
      logic down;
      logic left;
      logic right;
      logic start;
   } pad_btn_t;

   // Raw bits are active-low; an all-zero frame means the line is pulled low (no pad).
   // Opposing directions pressed together cancel each other out.
   function automatic pad_btn_t decode_pad(input logic [15:0] raw);
      pad_btn_t b;
      b.present = |raw;
      b.up      = b.present & ~raw[BIT_UP]    &  raw[BIT_DOWN];
      b.down    = b.present & ~raw[BIT_DOWN]  &  raw[BIT_UP];
      b.left    = b.present & ~raw[BIT_LEFT]  &  raw[BIT_RIGHT];
      b.right   = b.present & ~raw[BIT_RIGHT] &  raw[BIT_LEFT];
      b.start   = b.present & ~raw[BIT_START];
      return b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gamepad_reader_sync2.sv
// ============================================================================
// gamepad_reader_sync2 : two-flop synchroniser with settable reset level  (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gamepad_reader_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/gamepad_reader.sv
// ============================================================================
// gamepad_reader : polls an SNES-style pad (latch + 16 clocked bits)  (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gamepad_reader
   import gamepad_reader_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_poll,
   input  logic i_data,
   output logic o_latch,
   output logic o_pclk,
   output logic o_up,
   output logic o_down,
   output logic o_left,
   output logic o_right,
   output logic o_start,
   output logic o_valid,
   output logic o_busy,
   output logic o_present
);

   localparam logic [8:0] PHASE_LAST = 9'(DIV - 1);
   localparam logic [8:0] LATCH_LAST = 9'(2 * DIV - 1);

   state_e      state_q;
   logic [8:0]  cnt_q;
   logic [3:0]  slot_q;
   logic [15:0] shift_q;
   logic        latch_q, pclk_q, valid_q, busy_q;
   pad_btn_t    btn_q;
   pad_btn_t    pad_d;
   logic        data_s;

   gamepad_reader_sync2 #(.RESET_VAL(1'b1)) u_sync2 (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (i_data),
      .q_o   (data_s)
   );

   always_comb begin
      pad_d = decode_pad(shift_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 9'd0;
         slot_q  <= 4'd0;
         shift_q <= 16'd0;
         latch_q <= 1'b0;
         pclk_q  <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         btn_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_poll) begin
                  state_q <= ST_LATCH;
                  latch_q <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= 9'd0;
                  slot_q  <= 4'd0;
               end
            end
            ST_LATCH: begin
               if (cnt_q == LATCH_LAST) begin
                  cnt_q   <= 9'd0;
                  latch_q <= 1'b0;
                  pclk_q  <= 1'b0;
                  state_q <= ST_LOW;
               end else begin
                  cnt_q <= cnt_q + 9'd1;
               end
            end
            ST_LOW: begin
               // The pad has had a full HIGH+LOW to settle, so sample at the very end.
               if (cnt_q == PHASE_LAST) begin
                  shift_q[slot_q] <= data_s;
                  cnt_q   <= 9'd0;
                  pclk_q  <= 1'b1;
                  state_q <= ST_HIGH;
               end else begin
                  cnt_q <= cnt_q + 9'd1;
               end
            end
            ST_HIGH: begin
               if (cnt_q == PHASE_LAST) begin
                  cnt_q <= 9'd0;
                  if (slot_q == 4'd15) begin
                     btn_q   <= pad_d;
                     valid_q <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     slot_q  <= slot_q + 4'd1;
                     pclk_q  <= 1'b0;
                     state_q <= ST_LOW;
                  end
               end else begin
                  cnt_q <= cnt_q + 9'd1;
               end
            end
            ST_DONE: begin
               slot_q  <= 4'd0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               latch_q <= 1'b0;
               pclk_q  <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= 9'd0;
               slot_q  <= 4'd0;
            end
         endcase
      end
   end

   assign o_latch   = latch_q;
   assign o_pclk    = pclk_q;
   assign o_valid   = valid_q;
   assign o_busy    = busy_q;
   assign o_present = btn_q.present;
   assign o_up      = btn_q.up;
   assign o_down    = btn_q.down;
   assign o_left    = btn_q.left;
   assign o_right   = btn_q.right;
   assign o_start   = btn_q.start;

endmodule

`default_nettype wire

// File: tb/tb_gamepad_reader.sv
// ============================================================================
// tb_gamepad_reader : pad model, cycle-level reference model and directed reads  (rev 1.0)
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gamepad_reader;

   localparam int DIV      = 4;
   localparam int READ_LEN = 34 * DIV;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i_poll = 1'b0;
   logic i_data;
   logic o_latch, o_pclk, o_up, o_down, o_left, o_right, o_start;
   logic o_valid, o_busy, o_present;

   int checks = 0;
   int errors = 0;

   gamepad_reader #(.DIV(DIV)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_poll    (i_poll),
      .i_data    (i_data),
      .o_latch   (o_latch),
      .o_pclk    (o_pclk),
      .o_up      (o_up),
      .o_down    (o_down),
      .o_left    (o_left),
      .o_right   (o_right),
      .o_start   (o_start),
      .o_valid   (o_valid),
      .o_busy    (o_busy),
      .o_present (o_present)
   );

   always #5 clk = ~clk;

   // Pad: latch reloads bit 0 onto the line, each pclk rising edge advances one bit.
   logic [15:0] pad_raw = 16'hFFFF;
   bit          tie0 = 1'b0;
   int          pad_idx = 16;
   always @(posedge o_latch) pad_idx = 0;
   always @(posedge o_pclk) if (pad_idx < 16) pad_idx = pad_idx + 1;
   assign i_data = tie0 ? 1'b0 : ((pad_idx < 16) ? pad_raw[pad_idx[3:0]] : 1'b1);

   // Expected buttons {present,up,down,left,right,start} from a raw frame.
   function automatic logic [5:0] expect_btn(input logic [15:0] raw);
      bit pressed [16];
      logic [5:0] r;
      for (int i = 0; i < 16; i++) pressed[i] = (raw[i] == 1'b0);
      if (raw == 16'd0) return 6'd0;
      r[5] = 1'b1;
      r[4] = pressed[4] && !pressed[5];
      r[3] = pressed[5] && !pressed[4];
      r[2] = pressed[6] && !pressed[7];
      r[1] = pressed[7] && !pressed[6];
      r[0] = pressed[3];
      return r;
   endfunction

   function automatic logic exp_pclk(input int t);
      if (t < 2 * DIV || t >= READ_LEN) return 1'b1;
      return (((t - 2 * DIV) / DIV) % 2) == 1;
   endfunction

   // Reference model: a read is simply "cycle t of READ_LEN+1" after the poll.
   bit         m_init = 1'b0;
   bit         m_run = 1'b0;
   int         m_t = 0;
   logic [5:0] m_btn = 6'd0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_init <= 1'b1;
         m_run  <= 1'b0;
         m_t    <= 0;
         m_btn  <= 6'd0;
      end else if (m_run) begin
         if (m_t == READ_LEN) m_run <= 1'b0;
         else m_t <= m_t + 1;
         if (m_t == READ_LEN - 1) m_btn <= expect_btn(tie0 ? 16'd0 : pad_raw);
      end else if (i_poll) begin
         m_run <= 1'b1;
         m_t   <= 0;
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_init) begin
         check("busy",    o_busy,    m_run);
         check("latch",   o_latch,   m_run && m_t < 2 * DIV);
         check("pclk",    o_pclk,    m_run ? exp_pclk(m_t) : 1'b1);
         check("valid",   o_valid,   m_run && m_t == READ_LEN);
         check("present", o_present, m_btn[5]);
         check("up",      o_up,      m_btn[4]);
         check("down",    o_down,    m_btn[3]);
         check("left",    o_left,    m_btn[2]);
         check("right",   o_right,   m_btn[1]);
         check("start",   o_start,   m_btn[0]);
      end
   end

   // Event counters used for the literal per-read expectations.
   int   ncyc = 0, latch_high = 0, latch_rises = 0, pclk_falls = 0, valid_pulses = 0;
   int   first_latch_cyc = 0, valid_cyc = 0;
   logic latch_prev = 1'b0, pclk_prev = 1'b1;
   always @(negedge clk) begin
      ncyc <= ncyc + 1;
      latch_prev <= o_latch;
      pclk_prev  <= o_pclk;
      if (o_latch === 1'b1) begin
         latch_high <= latch_high + 1;
         if (latch_prev !== 1'b1) begin
            latch_rises     <= latch_rises + 1;
            first_latch_cyc <= ncyc;
         end
      end
      if (pclk_prev === 1'b1 && o_pclk === 1'b0) pclk_falls <= pclk_falls + 1;
      if (o_valid === 1'b1) begin
         valid_pulses <= valid_pulses + 1;
         valid_cyc    <= ncyc;
      end
   end

   task automatic pulse_poll();
      @(posedge clk);
      #1 i_poll = 1'b1;
      @(posedge clk);
      #1 i_poll = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int v0);
      bit seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(posedge clk);
         if (valid_pulses > v0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: got no o_valid, required one within 400 cycles", name);
      end
   endtask

   task automatic check_btn(input string name, input logic [5:0] exp);
      check({name, ".present"}, o_present, exp[5]);
      check({name, ".up"},      o_up,      exp[4]);
      check({name, ".down"},    o_down,    exp[3]);
      check({name, ".left"},    o_left,    exp[2]);
      check({name, ".right"},   o_right,   exp[1]);
      check({name, ".start"},   o_start,   exp[0]);
   endtask

   task automatic run_read(input string name, input logic [15:0] raw, input bit t0,
                           input logic [5:0] exp);
      int v0, lh0, pf0, lr0;
      pad_raw = raw;
      tie0    = t0;
      v0  = valid_pulses;
      lh0 = latch_high;
      pf0 = pclk_falls;
      lr0 = latch_rises;
      pulse_poll();
      wait_valid(name, v0);
      check_int({name, ".latch_cycles"}, latch_high - lh0, 2 * DIV);
      check_int({name, ".latch_rises"},  latch_rises - lr0, 1);
      check_int({name, ".pclk_falls"},   pclk_falls - pf0, 16);
      check_int({name, ".valid_cycle"},  valid_cyc - first_latch_cyc, 136);
      check_int({name, ".valid_count"},  valid_pulses - v0, 1);
      check_btn(name, exp);
   endtask

   initial begin
      int v0, lr0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.pclk", o_pclk, 1'b1);
      check("rst.latch", o_latch, 1'b0);
      check("rst.busy", o_busy, 1'b0);
      check("rst.valid", o_valid, 1'b0);
      check_btn("rst", 6'b000000);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      run_read("up_start", 16'hFFE7, 1'b0, 6'b110001);
      run_read("unplugged", 16'hFFFF, 1'b1, 6'b000000);
      run_read("up_down_left", 16'hFF8F, 1'b0, 6'b100100);

      // Extra polls mid-read must neither restart nor queue a read.
      pad_raw = 16'hFFFF;
      tie0    = 1'b0;
      v0  = valid_pulses;
      lr0 = latch_rises;
      @(posedge clk);
      #1 i_poll = 1'b1;
      @(posedge clk);
      #1 i_poll = 1'b0;
      repeat (9) @(posedge clk);
      #1 i_poll = 1'b1;
      @(posedge clk);
      #1 i_poll = 1'b0;
      repeat (39) @(posedge clk);
      #1 i_poll = 1'b1;
      @(posedge clk);
      #1 i_poll = 1'b0;
      wait_valid("poll_ignore", v0);
      repeat (40) @(posedge clk);
      check_int("poll_ignore.valid_count", valid_pulses - v0, 1);
      check_int("poll_ignore.latch_rises", latch_rises - lr0, 1);
      check("poll_ignore.busy", o_busy, 1'b0);
      check_btn("poll_ignore", 6'b100000);

      run_read("left", 16'hFFBF, 1'b0, 6'b100100);
      run_read("right", 16'hFF7F, 1'b0, 6'b100010);

      // Reset lands in the LOW phase of slot 7 (cycle 65 of the read).
      pad_raw = 16'hFFE7;
      v0 = valid_pulses;
      @(posedge clk);
      #1 i_poll = 1'b1;
      @(posedge clk);
      #1 i_poll = 1'b0;
      repeat (64) @(posedge clk);
      #1;
      check("pre_reset.busy", o_busy, 1'b1);
      check("pre_reset.pclk", o_pclk, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("mid_reset.pclk", o_pclk, 1'b1);
      check("mid_reset.latch", o_latch, 1'b0);
      check("mid_reset.busy", o_busy, 1'b0);
      check_btn("mid_reset", 6'b000000);
      repeat (200) @(posedge clk);
      check_int("mid_reset.valid_count", valid_pulses - v0, 0);
      check("mid_reset.idle", o_busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
